// File: rtl/rex_pkg.sv
// -----------------------------------------------------------------------------
// rex_pkg
// Shared definitions for the Rex Runner game sequencer and pixel decider.
//   - game_state_t : state encodings driven on game_state
//   - geometry     : rex and obstacle box sizes, screen height
//   - satInc16     : saturating 16-bit increment used for the score
// -----------------------------------------------------------------------------
package rex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   localparam int REX_LEFT = 8;
   localparam int REX_W    = 24;
   localparam int REX_H    = 23;
   localparam int OBST_W   = 16;
   localparam int OBST_H   = 22;
   localparam int SCREEN_H = 64;

   // Score sticks at all-ones instead of wrapping back to zero
   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rex_btn_edge.sv
// -----------------------------------------------------------------------------
// rex_btn_edge
// Brings the raw jump button into the clk domain and turns each press into a
// single-cycle pulse. The pulse appears 3 clk after the raw rising edge
// (two synchronizer flops, then a registered edge detect).
// Ports:
//   clk     in   system clock
//   rstn    in   asynchronous active-low reset
//   i_btn   in   raw asynchronous button, active-high
//   o_press out  one-cycle press pulse
// -----------------------------------------------------------------------------
module rex_btn_edge (
   input  logic clk,
   input  logic rstn,
   input  logic i_btn,
   output logic o_press
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_press;

   // Two-flop synchronizer followed by a registered rising-edge detector;
   // r_prev holds the previous synchronized level so a held button fires once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_press <= r_sync2 & ~r_prev;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/rex_game_ctrl.sv
// -----------------------------------------------------------------------------
// rex_game_ctrl
// Per-frame game sequencer for Rex Runner: game state machine, rex jump
// physics, obstacle scrolling/respawn, collision detection and score. All game
// updates happen on frame_tick while running and land one clk later.
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per frame
//   btn_jump      in   raw asynchronous jump button, active-high
//   rex_down      out  rex bottom y, 0 = ground
//   obstacle_left out  obstacle left x, two's complement
//   game_state    out  0 = IDLE, 1 = RUN, 2 = OVER
//   score         out  obstacles cleared, saturating
// Build option:
//   REX_SPEEDUP_EN  when defined, obstacle speed grows by one every 8 points,
//                   capped at MAX_SPEED; otherwise speed is fixed at SPEED.
// -----------------------------------------------------------------------------
module rex_game_ctrl
   import rex_pkg::*;
#(
   parameter int SCREEN_W  = 128,
   parameter int SPEED     = 4,
   parameter int MAX_SPEED = 8,
   parameter int JUMP_V    = 8,
   parameter int GRAVITY   = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        frame_tick,
   input  logic        btn_jump,
   output logic [15:0] rex_down,
   output logic [15:0] obstacle_left,
   output logic [1:0]  game_state,
   output logic [15:0] score
);

   // Obstacle leaves the screen once fully left of x = 0; collision box edges
   // follow from the rex occupying x [REX_LEFT, REX_LEFT+REX_W).
   localparam logic signed [15:0] OBS_GONE_X = 16'(-OBST_W);
   localparam logic signed [15:0] HIT_X_HI   = 16'(REX_LEFT + REX_W);
   localparam logic signed [15:0] HIT_X_LO   = 16'(REX_LEFT - OBST_W);
   localparam logic [15:0]        HIT_Y      = 16'(OBST_H);

   game_state_t        r_state;
   logic [15:0]        r_rex;
   logic signed [7:0]  r_vel;
   logic signed [15:0] r_obs;
   logic [15:0]        r_score;
   logic               r_jumpPend;

   logic               w_press;
   logic [15:0]        w_speed;
   logic signed [7:0]  w_velEff;
   logic signed [16:0] w_nrex;
   logic [15:0]        w_rexNext;
   logic signed [7:0]  w_velNext;
   logic signed [15:0] w_nobs;
   logic signed [15:0] w_obsNext;
   logic [15:0]        w_scoreNext;
   logic               w_hit;

   rex_btn_edge u_btn (
      .clk     (clk),
      .rstn    (rstn),
      .i_btn   (btn_jump),
      .o_press (w_press)
   );

`ifdef REX_SPEEDUP_EN
   logic [16:0] w_rawSpeed;

   // One extra pixel per frame for every 8 points, clamped at the ceiling
   assign w_rawSpeed = 17'(SPEED) + {4'd0, r_score[15:3]};
   assign w_speed    = (w_rawSpeed > 17'(MAX_SPEED)) ? 16'(MAX_SPEED) : w_rawSpeed[15:0];
`else
   // Fixed speed; the ceiling only matters if SPEED was set above it
   localparam int BASE_SPEED = (SPEED < MAX_SPEED) ? SPEED : MAX_SPEED;
   assign w_speed = 16'(BASE_SPEED);
`endif

   // Next-frame physics, evaluated every cycle and committed only on a tick.
   // A press in the tick cycle counts as pending so it is not lost.
   always_comb begin
      w_velEff = r_vel;
      if ((r_jumpPend || w_press) && (r_rex == 16'd0) && (r_vel == 8'sd0)) begin
         w_velEff = 8'(JUMP_V);
      end

      w_nrex = $signed({1'b0, r_rex}) + 17'(w_velEff);
      if (w_nrex <= 17'sd0) begin
         w_rexNext = 16'd0;
         w_velNext = 8'sd0;
      end else begin
         w_rexNext = w_nrex[15:0];
         w_velNext = w_velEff - 8'(GRAVITY);
      end

      w_nobs      = r_obs - $signed(w_speed);
      w_obsNext   = w_nobs;
      w_scoreNext = r_score;
      if (w_nobs <= OBS_GONE_X) begin
         w_obsNext   = 16'(SCREEN_W);
         w_scoreNext = satInc16(r_score);
      end

      w_hit = (w_obsNext < HIT_X_HI) && (w_obsNext > HIT_X_LO) && (w_rexNext < HIT_Y);
   end

   // Game state machine. IDLE and OVER wait for a press and freeze everything;
   // RUN latches presses as a pending jump and applies the frame update on tick,
   // dropping into OVER with the colliding positions kept on screen.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_rex      <= 16'd0;
         r_vel      <= 8'sd0;
         r_obs      <= 16'(SCREEN_W);
         r_score    <= 16'd0;
         r_jumpPend <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_OVER: begin
               if (w_press) begin
                  r_state    <= ST_RUN;
                  r_rex      <= 16'd0;
                  r_vel      <= 8'sd0;
                  r_obs      <= 16'(SCREEN_W);
                  r_score    <= 16'd0;
                  r_jumpPend <= 1'b0;
               end
            end
            ST_RUN: begin
               if (frame_tick) begin
                  r_rex      <= w_rexNext;
                  r_vel      <= w_velNext;
                  r_obs      <= w_obsNext;
                  r_score    <= w_scoreNext;
                  r_jumpPend <= 1'b0;
                  if (w_hit) begin
                     r_state <= ST_OVER;
                  end
               end else if (w_press) begin
                  r_jumpPend <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rex_down      = r_rex;
   assign obstacle_left = r_obs;
   assign game_state    = r_state;
   assign score         = r_score;

endmodule

// File: tb/tb_rex_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rex_game_ctrl
// Directed scoreboard bench for rex_game_ctrl. Stimulus pushes the expected
// outputs whenever it issues a frame tick, a snapshot request or an async
// reset; separate monitor processes pop and compare when the DUT responds.
// -----------------------------------------------------------------------------
module tb_rex_game_ctrl;
   import rex_pkg::*;

   logic        clk;
   logic        rstn;
   logic        frame_tick;
   logic        btn_jump;
   logic [15:0] rex_down;
   logic [15:0] obstacle_left;
   logic [1:0]  game_state;
   logic [15:0] score;
   logic        snapReq;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic [15:0] rex;
      logic [15:0] obs;
      logic [15:0] sc;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   // Hand-computed jump heights for JUMP_V = 8, GRAVITY = 1
   int jumpProf[17] = '{8, 15, 21, 26, 30, 33, 35, 36, 36, 35, 33, 30, 26, 21, 15, 8, 0};

   rex_game_ctrl dut (
      .clk           (clk),
      .rstn          (rstn),
      .frame_tick    (frame_tick),
      .btn_jump      (btn_jump),
      .rex_down      (rex_down),
      .obstacle_left (obstacle_left),
      .game_state    (game_state),
      .score         (score)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compareField(input string nm, input string fld,
                               input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s.%s actual=%0d required=%0d", nm, fld, $signed(act), $signed(req));
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
         e = expQ.pop_front();
         compareField(e.name, "state", {14'd0, game_state}, {14'd0, e.st});
         compareField(e.name, "rex",   rex_down,      e.rex);
         compareField(e.name, "obs",   obstacle_left, e.obs);
         compareField(e.name, "score", score,         e.sc);
      end
   endtask

   // Monitor: a tick or snapshot sampled at a rising edge means fresh outputs
   // are ready; look at them 1 ns after that edge.
   initial begin : monClk
      bit fire;
      forever begin
         @(posedge clk);
         fire = frame_tick | snapReq;
         #1;
         if (fire) checkOutput();
      end
   end

   // Monitor: reset must clear outputs without waiting for a clock edge
   initial begin : monRst
      forever begin
         @(negedge rstn);
         #1;
         checkOutput();
      end
   end

   // Issue one tick or snapshot request; always entered and left at a negedge
   task automatic applyStimulus(input bit tick, input bit snap, input string nm,
                                input logic [1:0] st, input int rex, input int obs,
                                input int sc);
      exp_t e;
      e.name = nm;
      e.st   = st;
      e.rex  = 16'(rex);
      e.obs  = 16'(obs);
      e.sc   = 16'(sc);
      expQ.push_back(e);
      frame_tick = tick;
      snapReq    = snap;
      @(negedge clk);
      frame_tick = 1'b0;
      snapReq    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raw press; the synchronized pulse is seen by the FSM at the 4th rising edge,
   // i.e. the edge right after this task returns
   task automatic pressHold();
      btn_jump = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic releaseBtn();
      btn_jump = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic asyncReset(input string nm);
      exp_t e;
      #2;
      e.name = nm;
      e.st   = ST_IDLE;
      e.rex  = 16'd0;
      e.obs  = 16'd128;
      e.sc   = 16'd0;
      expQ.push_back(e);
      rstn = 1'b0;
      #12;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // Watchdog so the run can never hang
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stim
      int obs;
      int sc;
      logic [1:0] st;

      rstn       = 1'b1;
      frame_tick = 1'b0;
      btn_jump   = 1'b0;
      snapReq    = 1'b0;

      // Power-on reset, then ticks in IDLE change nothing
      asyncReset("por");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1, 0, "idle_tick", ST_IDLE, 0, 128, 0);
         idle(1);
      end

      // Start, then run grounded into the obstacle
      pressHold();
      applyStimulus(0, 1, "start", ST_RUN, 0, 128, 0);
      releaseBtn();
      for (int k = 1; k <= 25; k++) begin
         st = (k == 25) ? ST_OVER : ST_RUN;
         applyStimulus(1, 0, "ground", st, 0, 128 - 4 * k, 0);
         idle(1);
      end
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, "over_frozen", ST_OVER, 0, 28, 0);
         idle(1);
      end

      // Restart, then clear the obstacle with a jump pressed between ticks 21 and 22
      pressHold();
      applyStimulus(0, 1, "restart0", ST_RUN, 0, 128, 0);
      releaseBtn();
      for (int k = 1; k <= 21; k++) begin
         applyStimulus(1, 0, "pre_jump", ST_RUN, 0, 128 - 4 * k, 0);
         idle(1);
      end
      pressHold();
      releaseBtn();
      idle(2);
      for (int k = 22; k <= 61; k++) begin
         if (k < 36) obs = 128 - 4 * k;
         else        obs = 128 - 4 * (k - 36);
         sc = (k >= 36) ? 1 : 0;
         st = (k == 61) ? ST_OVER : ST_RUN;
         applyStimulus(1, 0, "clear_jump", st, (k <= 38) ? jumpProf[k - 22] : 0, obs, sc);
         idle(1);
      end

      // Restart from OVER with score 1
      pressHold();
      applyStimulus(0, 1, "restart1", ST_RUN, 0, 128, 0);
      releaseBtn();
      idle(2);

      // Press landing in the same cycle as a tick jumps on that tick
      pressHold();
      applyStimulus(1, 0, "coincide", ST_RUN, jumpProf[0], 124, 0);
      releaseBtn();
      for (int k = 2; k <= 5; k++) begin
         applyStimulus(1, 0, "airborne", ST_RUN, jumpProf[k - 1], 128 - 4 * k, 0);
         idle(1);
      end

      // Press at rex_down = 30 is dropped; the profile continues unchanged
      pressHold();
      releaseBtn();
      idle(2);
      for (int k = 6; k <= 17; k++) begin
         applyStimulus(1, 0, "air_press", ST_RUN, jumpProf[k - 1], 128 - 4 * k, 0);
         idle(1);
      end
      applyStimulus(1, 0, "no_rejump", ST_RUN, 0, 56, 0);
      idle(1);

      // Jump again and reset asynchronously mid-air
      pressHold();
      releaseBtn();
      idle(2);
      for (int k = 19; k <= 21; k++) begin
         applyStimulus(1, 0, "jump2", ST_RUN, jumpProf[k - 19], 128 - 4 * k, 0);
         idle(1);
      end
      asyncReset("mid_reset");
      applyStimulus(0, 1, "after_reset", ST_IDLE, 0, 128, 0);
      applyStimulus(1, 0, "after_reset_tick", ST_IDLE, 0, 128, 0);
      idle(3);

      // Every expectation must have been consumed
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
